// File: rtl/popcount_arbiter_if.sv
// ---------------------------------------------------------------------------
// popcount_arbiter_if : requester-side bus of the shared popcount arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface popcount_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 6,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic [CNT_W-1:0]          result;
  logic                      result_valid;
  logic [ID_W-1:0]           result_id;

  modport master (
    output req, req_data,
    input  grant, busy, result, result_valid, result_id
  );

  modport slave (
    input  req, req_data,
    output grant, busy, result, result_valid, result_id
  );
endinterface

`default_nettype wire

// File: rtl/popcount_arbiter.sv
// ---------------------------------------------------------------------------
// popcount_arbiter : round-robin shared byte-serial ones counter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module popcount_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 6,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  popcount_arbiter_if.slave   bus
);

  localparam int CHUNKS  = DATA_W / 8;
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic [ID_W-1:0]    result_id_q, result_id_d;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    cand;
  logic [CNT_W-1:0]   acc_sum;

  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, b[i]};
    end
    return n;
  endfunction

  // Search starts one past the last winner so every held request is reached
  // within NUM_REQ grants.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_id_q) + k) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign acc_sum = acc_q + CNT_W'(pop8(shift_q[7:0]));

  always_comb begin
    state_d        = state_q;
    last_id_d      = last_id_q;
    shift_d        = shift_q;
    acc_d          = acc_q;
    chunk_d        = chunk_q;
    grant_d        = '0;
    busy_d         = busy_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    result_id_d    = result_id_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          shift_d   = bus.req_data[int'(win_id)*DATA_W +: DATA_W];
          acc_d     = '0;
          chunk_d   = '0;
          last_id_d = win_id;
          grant_d   = NUM_REQ'(1) << win_id;
          busy_d    = 1'b1;
          state_d   = ST_COUNT;
        end
      end
      ST_COUNT: begin
        acc_d   = acc_sum;
        shift_d = shift_q >> 8;
        chunk_d = chunk_q + CHUNK_W'(1);
        if (chunk_q == CHUNK_W'(CHUNKS - 1)) begin
          result_d       = acc_sum;
          result_id_d    = last_id_q;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      last_id_q      <= ID_W'(NUM_REQ - 1);
      shift_q        <= '0;
      acc_q          <= '0;
      chunk_q        <= '0;
      grant_q        <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
    end else begin
      state_q        <= state_d;
      last_id_q      <= last_id_d;
      shift_q        <= shift_d;
      acc_q          <= acc_d;
      chunk_q        <= chunk_d;
      grant_q        <= grant_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_id    = result_id_q;

endmodule

`default_nettype wire

// File: doc/popcount_arbiter.md
Name: popcount_arbiter

Overview:
- Shares one 8-bit ones-counting datapath among NUM_REQ requesters.
- Each requester presents a DATA_W-bit word; a round-robin arbiter grants one requester at a time and captures its word.
- A sequencer feeds the word through the shared 8-bit counter one byte per cycle, then returns the total ones count tagged with the requester ID.
- Sits between the requesting blocks and the combinational ones-count function, replacing per-requester counter copies.

Parameters:
- NUM_REQ, 4: number of requesters; must be >= 2.
- DATA_W, 32: word width; must be a multiple of 8 and >= 8. CHUNKS = DATA_W/8.
- CNT_W, 6: result width; must be >= clog2(DATA_W+1).
- ID_W, 2: requester ID width; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request per requester; held with data until grant is seen.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i at [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot, one-cycle pulse; the word was captured at the edge that raised it.
- busy  out  1  high whenever the FSM is not IDLE.
- result  out  CNT_W  ones count of the last completed word; holds until the next completion.
- result_valid  out  1  one-cycle pulse marking a new result.
- result_id  out  ID_W  ID of the requester that owns result; holds with result.

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to IDLE.
  - grant, busy, result, result_valid and result_id all go to 0.
  - Internal shift register, accumulator and chunk counter are cleared.
  - RR pointer last_id = NUM_REQ-1, so requester 0 has priority first.
- FSM states are IDLE, COUNT and DONE. All outputs are registered.
- IDLE:
  - If any req bit is high, select the first set bit searching last_id+1, last_id+2, ... modulo NUM_REQ.
  - At that edge: load its req_data into the shift register, clear the accumulator and chunk counter, set last_id to the winner, pulse grant[winner], set busy=1, go to COUNT.
  - If req is all zero, stay in IDLE.
- COUNT, each edge:
  - acc <= acc + popcount(shift[7:0]), where popcount is an 8-bit function returning 4 bits, zero-extended to CNT_W.
  - Shift right by 8 and increment the chunk counter.
  - On the CHUNKS-th COUNT edge: result <= final sum, result_id <= last_id, result_valid <= 1, go to DONE.
- DONE: result_valid is high for this one cycle. Next edge: result_valid=0, busy=0, go to IDLE.
- Timing:
  - Grant at edge E; result_valid high in the cycle following edge E+CHUNKS, and low again after edge E+CHUNKS+1.
  - Earliest next grant is at edge E+CHUNKS+2, so throughput is one word per CHUNKS+2 cycles (6 cycles for the defaults).
- Arithmetic: no overflow is possible, given the CNT_W constraint. An all-ones word yields exactly DATA_W.
- Requester rules:
  - A requester must drop req within CHUNKS+1 cycles after seeing its grant. A req still high when the FSM returns to IDLE is treated as a new request.
  - req or req_data changes during COUNT/DONE are ignored; the word is already captured.
  - A req withdrawn in IDLE before being granted produces no grant.
- Fairness: with multiple requests in the same IDLE cycle, exactly one is granted and the others wait. Each continuously-held requester is served within NUM_REQ grants.
- Reset asserted mid-COUNT or mid-DONE aborts the operation: no result_valid is produced and the pointer returns to NUM_REQ-1.

Test Plan:
1. Reset check: hold rst_n low with random req/req_data -> grant=0, busy=0, result=0, result_valid=0, result_id=0. Release with req=0 -> outputs stay 0.
2. Single request, req[0]=1 with data 0xFFFFFFFF -> grant=4'b0001 for one cycle, busy=1. result_valid pulses 4 cycles after grant with result=32, result_id=0. busy drops one cycle later.
3. Value sweep via requester 1 -> expected counts:
   - 0x00000000 -> 0
   - 0x80000001 -> 2
   - 0x0F0F0F0F -> 16
   - 0xA5A5A5A5 -> 16
   - 0x00000100 -> 1
   result_id=1 in each case.
4. Contention: req=4'b1111 at once with data 0x1, 0x3, 0x7, 0xF, each req dropped after its grant -> grants in order 0,1,2,3, spaced 6 cycles. Results 1,2,3,4 with matching IDs.
5. Fairness: req[0] and req[2] held continuously -> grant sequence 0,2,0,2,... Requester 1 raised later -> granted within 3 grants.
6. Reset mid-op: assert rst_n low 2 cycles after grant to requester 3 -> all outputs 0 immediately and no result_valid. After release with req=4'b1010 -> requester 1 is granted first.
